// File: rtl/hu_id_ex_stage_pkg.sv
// Shared pipeline configuration for the ID->EX stage: widths, control bundle, bubble value.
package hu_id_ex_stage_pkg;

   localparam int XLEN    = 32;
   localparam int ALUOP_W = 4;

   // Control bits that travel with an instruction from ID into EX
   typedef struct packed {
      logic               RegWrite;
      logic               MemRead;
      logic               reg_ren;
      logic               auipc;
      logic               ALU_DB_Src;
      logic [ALUOP_W-1:0] ALUop;
   } ctrl_t;

   // A bubble is an all-zero control bundle: no write, no load, no side effects
   localparam ctrl_t BUBBLE = '0;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      if (v == 32'hFFFF_FFFF) begin
         return v;
      end
      return v + 32'd1;
   endfunction

endpackage

// File: rtl/hu_load_use_detect.sv
// Combinational load-use hazard detection and front-end stall generation.
module hu_load_use_detect
   import hu_id_ex_stage_pkg::*;
(
   input  logic       valid_D,
   input  logic       reg_ren_D,
   input  logic       ALU_DB_Src_D,
   input  logic [4:0] Rs1_D,
   input  logic [4:0] Rs2_D,
   input  logic       valid_E,
   input  logic       MemRead_E,
   input  logic [4:0] Rd_E,
   input  logic       flush_E,
   input  logic       mem_stall,
   output logic       load_use,
   output logic       stall_F,
   output logic       stall_D
);

   logic rs1_match;
   logic rs2_match;

   // A load in EX whose result is read by ID; Rd_E != 0 also excludes x0 sources.
   // Rs2 only counts when the ALU B operand actually comes from rs2.
   always_comb begin
      rs1_match = (Rd_E == Rs1_D);
      rs2_match = ALU_DB_Src_D & (Rd_E == Rs2_D);
      load_use  = valid_D & MemRead_E & valid_E & (Rd_E != 5'd0) & reg_ren_D
                  & (rs1_match | rs2_match);
      // A taken flush kills the dependent instruction, so it need not wait
      stall_F   = mem_stall | (load_use & ~flush_E);
      stall_D   = stall_F;
   end

endmodule

// File: rtl/hu_id_ex_stage.sv
// ID->EX pipeline register with load-use bubble insertion, flush, memory-stall hold
// and W->D write-through bypass of register operands.
module hu_id_ex_stage
   import hu_id_ex_stage_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               valid_D,
   input  logic [XLEN-1:0]    PC_reg_D,
   input  logic [XLEN-1:0]    rdata1_D,
   input  logic [XLEN-1:0]    rdata2_D,
   input  logic [XLEN-1:0]    imme_D,
   input  logic [4:0]         Rs1_D,
   input  logic [4:0]         Rs2_D,
   input  logic [4:0]         Rd_D,
   input  logic               RegWrite_D,
   input  logic               MemRead_D,
   input  logic               reg_ren_D,
   input  logic               auipc_D,
   input  logic               ALU_DB_Src_D,
   input  logic [ALUOP_W-1:0] ALUop_D,
   input  logic               RegWrite_W,
   input  logic [4:0]         Rd_W,
   input  logic [XLEN-1:0]    rdata_reg_W,
   input  logic               flush_E,
   input  logic               mem_stall,
   output logic               valid_E,
   output logic [XLEN-1:0]    PC_reg_E,
   output logic [XLEN-1:0]    rdata1_E,
   output logic [XLEN-1:0]    rdata2_E,
   output logic [XLEN-1:0]    imme_E,
   output logic [4:0]         Rs1_E,
   output logic [4:0]         Rs2_E,
   output logic [4:0]         Rd_E,
   output logic               RegWrite_E,
   output logic               MemRead_E,
   output logic               reg_ren_E,
   output logic               auipc_E,
   output logic               ALU_DB_Src_E,
   output logic [ALUOP_W-1:0] ALUop_E,
   output logic               stall_F,
   output logic               stall_D,
   output logic [31:0]        bubble_cnt
);

   ctrl_t           ctrl_D;
   ctrl_t           ctrl_E;
   logic [XLEN-1:0] op1_D;
   logic [XLEN-1:0] op2_D;
   logic            load_use;

   hu_load_use_detect u_detect (
      .valid_D      (valid_D),
      .reg_ren_D    (reg_ren_D),
      .ALU_DB_Src_D (ALU_DB_Src_D),
      .Rs1_D        (Rs1_D),
      .Rs2_D        (Rs2_D),
      .valid_E      (valid_E),
      .MemRead_E    (ctrl_E.MemRead),
      .Rd_E         (Rd_E),
      .flush_E      (flush_E),
      .mem_stall    (mem_stall),
      .load_use     (load_use),
      .stall_F      (stall_F),
      .stall_D      (stall_D)
   );

   // Bundle ID control and resolve the same-cycle W write that the regfile read missed
   always_comb begin
      ctrl_D.RegWrite   = RegWrite_D;
      ctrl_D.MemRead    = MemRead_D;
      ctrl_D.reg_ren    = reg_ren_D;
      ctrl_D.auipc      = auipc_D;
      ctrl_D.ALU_DB_Src = ALU_DB_Src_D;
      ctrl_D.ALUop      = ALUop_D;
      op1_D = (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == Rs1_D)) ? rdata_reg_W : rdata1_D;
      op2_D = (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == Rs2_D)) ? rdata_reg_W : rdata2_D;
   end

   // ID->EX register: reset > memory hold > flush/load-use bubble > normal capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_E    <= 1'b0;
         ctrl_E     <= BUBBLE;
         PC_reg_E   <= '0;
         rdata1_E   <= '0;
         rdata2_E   <= '0;
         imme_E     <= '0;
         Rs1_E      <= '0;
         Rs2_E      <= '0;
         Rd_E       <= '0;
         bubble_cnt <= '0;
      end else if (mem_stall) begin
         // whole front end frozen: every E register keeps its value
      end else if (flush_E || load_use) begin
         valid_E  <= 1'b0;
         ctrl_E   <= BUBBLE;
         PC_reg_E <= '0;
         rdata1_E <= '0;
         rdata2_E <= '0;
         imme_E   <= '0;
         Rs1_E    <= '0;
         Rs2_E    <= '0;
         Rd_E     <= '0;
         // only hazard bubbles are counted, not flush kills
         if (!flush_E) begin
            bubble_cnt <= sat_inc32(bubble_cnt);
         end
      end else begin
         valid_E  <= valid_D;
         ctrl_E   <= ctrl_D;
         PC_reg_E <= PC_reg_D;
         rdata1_E <= op1_D;
         rdata2_E <= op2_D;
         imme_E   <= imme_D;
         Rs1_E    <= Rs1_D;
         Rs2_E    <= Rs2_D;
         Rd_E     <= Rd_D;
      end
   end

   assign RegWrite_E   = ctrl_E.RegWrite;
   assign MemRead_E    = ctrl_E.MemRead;
   assign reg_ren_E    = ctrl_E.reg_ren;
   assign auipc_E      = ctrl_E.auipc;
   assign ALU_DB_Src_E = ctrl_E.ALU_DB_Src;
   assign ALUop_E      = ctrl_E.ALUop;

endmodule
